// File: rtl/inv_trans_divider_pkg.sv
// Shared SRSC constants for the inverse-transmission divider: fixed-point
// formats, the derived dividend, the default clamp and the FSM state type.
package inv_trans_divider_pkg;

    // Transmission arrives as Q0.8; the multiplier wants Q2.6.
    localparam int Q08_FRAC = 8;
    localparam int Q26_FRAC = 6;

    // 1/t in Q2.6 is (2^Q08_FRAC * 2^Q26_FRAC) / t_raw.
    localparam int DIVIDEND_DEFAULT = 1 << (Q08_FRAC + Q26_FRAC);

    // One iteration per dividend bit (16384 needs 15 bits).
    localparam int DIV_W_DEFAULT = Q08_FRAC + Q26_FRAC + 1;

    // 65 keeps 1/t at or below 3.94, i.e. inside the 8-bit Q2.6 range.
    localparam int T_MIN_DEFAULT = 65;

    localparam int TAG_W_DEFAULT = 8;

    // Remainder never reaches the divisor, so 9 bits hold the shifted value.
    localparam int REM_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the remainder, subtract the divisor when it fits.
module restoring_div_step
    import inv_trans_divider_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic             dividend_bit,
    input  logic [7:0]       divisor,
    output logic [REM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [REM_W:0] shifted;

    // Trial subtract; the difference is always below the divisor, so the
    // low REM_W bits carry the full result.
    always_comb begin
        shifted  = {rem, dividend_bit};
        q_bit    = (shifted >= {{(REM_W - 7){1'b0}}, divisor});
        rem_next = shifted[REM_W-1:0];
        if (q_bit) begin
            rem_next = shifted[REM_W-1:0] - {1'b0, divisor};
        end
    end

endmodule

// File: rtl/inv_trans_divider.sv
// Inverse-transmission divider: out_inv_trans = sat8(DIVIDEND / max(t, T_MIN))
// in Q2.6, computed by an iterative restoring divider, one bit per cycle.
//
// Handshake: a transfer happens on any rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, and out_inv_trans/out_tag stay frozen until the transfer completes.
module inv_trans_divider
    import inv_trans_divider_pkg::*;
#(
    parameter int T_MIN    = T_MIN_DEFAULT,
    parameter int TAG_W    = TAG_W_DEFAULT,
    parameter int DIVIDEND = DIVIDEND_DEFAULT,
    parameter int DIV_W    = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_trans,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_inv_trans,
    output logic [TAG_W-1:0] out_tag
);

    localparam int                CNT_W      = $clog2(DIV_W);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV_W - 1);
    localparam logic [7:0]        T_MIN_Q    = T_MIN[7:0];
    localparam logic [DIV_W-1:0]  DIVIDEND_Q = DIVIDEND[DIV_W-1:0];

    div_state_t       state;
    div_state_t       state_next;

    logic [7:0]       divisor_q;
    logic [DIV_W-1:0] quot_q;
    logic [REM_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;

    logic [REM_W-1:0] rem_next;
    logic             q_bit;
    logic [DIV_W-1:0] quot_next;
    logic [7:0]       t_clamped;
    logic [7:0]       result_sat;
    logic             accept;
    logic             out_fire;
    logic             last_step;

    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_step = (state == DIV) && (cnt_q == '0);

    // Clamp small transmissions so the divisor is never zero and 1/t fits.
    assign t_clamped = (in_trans < T_MIN_Q) ? T_MIN_Q : in_trans;

    // The quotient register doubles as the dividend shifter: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign quot_next = {quot_q[DIV_W-2:0], q_bit};

    // Anything above 255 (only reachable with T_MIN <= 64) pins to full scale.
    assign result_sat = (|quot_next[DIV_W-1:8]) ? 8'hFF : quot_next[7:0];

    restoring_div_step u_step (
        .rem          (rem_q),
        .dividend_bit (quot_q[DIV_W-1]),
        .divisor      (divisor_q),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: accept, iterate DIV_W times, hold until drained.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = DIV;
            DIV:     if (last_step) state_next = DONE;
            DONE:    if (out_fire)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output decode: only IDLE takes new work.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Divider datapath: load operands on accept, one restoring step per DIV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            divisor_q <= t_clamped;
            quot_q    <= DIVIDEND_Q;
            rem_q     <= '0;
            cnt_q     <= CNT_LAST;
            tag_q     <= in_tag;
        end else if (state == DIV) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Result registers: capture on the final step, release on the output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_inv_trans <= '0;
            out_tag       <= '0;
        end else if (last_step) begin
            out_valid     <= 1'b1;
            out_inv_trans <= result_sat;
            out_tag       <= tag_q;
        end else if (out_fire) begin
            out_valid     <= 1'b0;
        end
    end

endmodule
